uart_tx_ctrl: RTL and testbench

- Byte-level scheduler that sits in front of the UART transmitter.
- Accepts bytes from the CPU store path into a small FIFO.
- Sequences the transmitter's load_data_reg / byte_ready / transfer_byte strobes, paced by the baud tick.
- Tracks frame completion so that back-to-back bytes are sent without CPU polling per bit.

---
 rtl/uart_tx_ctrl.sv | 119 +++++++++++
 tb/tb_uart_tx_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// Byte scheduler in front of the UART transmitter: small FIFO plus strobe sequencing paced by tick.
// Optional transmit-complete interrupt enabled with `define UART_TX_IRQ_EN (adds tx_irq, irq_mask).
module uart_tx_ctrl #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       stop_2,
  output logic [7:0] tx_data,
  output logic       load_data_reg,
  output logic       byte_ready,
  output logic       transfer_byte,
  output logic       stop_2_q,
  output logic       fifo_full,
  output logic       fifo_empty,
  output logic       busy,
  output logic       ovf
`ifdef UART_TX_IRQ_EN
  ,
  input  logic       irq_mask,
  output logic       tx_irq
`endif
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = FIFO_DEPTH[PTR_W:0];

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_READY = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_SEND  = 3'd4;

  logic [2:0]       state;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count, count_nxt;
  logic [3:0]       frame_cnt, frame_len;
  logic             push, pop, send_done;

  assign push      = wr_en && !fifo_full;
  assign pop       = (state == S_IDLE) && !fifo_empty;
  assign frame_len = stop_2_q ? 4'd11 : 4'd10;
  // Last tick of the frame: the count would reach frame_len on this tick.
  assign send_done = (state == S_SEND) && tick && (frame_cnt >= frame_len - 4'd1);

  assign load_data_reg = (state == S_LOAD);
  assign byte_ready    = (state == S_READY);
  assign transfer_byte = (state == S_START);
  assign busy          = (state != S_IDLE);

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + (PTR_W+1)'(1);
      2'b01:   count_nxt = count - (PTR_W+1)'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fifo_full  <= 1'b0;
      fifo_empty <= 1'b1;
      ovf        <= 1'b0;
      tx_data    <= 8'h00;
      stop_2_q   <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      count      <= count_nxt;
      fifo_full  <= (count_nxt == DEPTH_C);
      fifo_empty <= (count_nxt == '0);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (wr_en && fifo_full) ovf <= 1'b1;
      // Each strobe state advances on the tick that the transmitter samples it.
      case (state)
        S_IDLE: if (pop) begin
          tx_data  <= mem[rd_ptr];
          stop_2_q <= stop_2;
          state    <= S_LOAD;
        end
        S_LOAD:  if (tick) state <= S_READY;
        S_READY: if (tick) state <= S_START;
        S_START: if (tick) begin
          frame_cnt <= '0;
          state     <= S_SEND;
        end
        S_SEND: if (tick) begin
          if (send_done) begin
            frame_cnt <= '0;
            state     <= S_IDLE;
          end else begin
            frame_cnt <= frame_cnt + 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef UART_TX_IRQ_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tx_irq <= 1'b0;
    else      tx_irq <= send_done && fifo_empty && !irq_mask;
  end
`endif

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Randomized bench for uart_tx_ctrl; a frame observer reduces pin activity to per-frame records
// that each test compares against expectations derived from the frame rules.
module tb_uart_tx_ctrl;
  localparam int DEPTH = 4;

  logic       clk = 0, rst = 1, tick = 0, wr_en = 0, stop_2 = 0;
  logic [7:0] wr_data = 0;
  logic [7:0] tx_data;
  logic       load_data_reg, byte_ready, transfer_byte, stop_2_q;
  logic       fifo_full, fifo_empty, busy, ovf;
`ifdef UART_TX_IRQ_EN
  logic       irq_mask = 0, tx_irq;
`endif

  uart_tx_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .tick(tick), .wr_en(wr_en), .wr_data(wr_data), .stop_2(stop_2),
    .tx_data(tx_data), .load_data_reg(load_data_reg), .byte_ready(byte_ready),
    .transfer_byte(transfer_byte), .stop_2_q(stop_2_q), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .busy(busy), .ovf(ovf)
`ifdef UART_TX_IRQ_EN
    , .irq_mask(irq_mask), .tx_irq(tx_irq)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0;
  int tick_div = 4, tcnt = 0;

  // tick_div==1 ties tick high; otherwise one tick every tick_div clocks
  always @(posedge clk) begin
    cyc++;
    #1;
    if (tick_div <= 1) tick = 1'b1;
    else begin
      tcnt = (tcnt + 1) % tick_div;
      tick = (tcnt == 0);
    end
  end

  typedef struct {
    logic [7:0] data;
    logic       s2;
    int ld_cyc, rd_cyc, st_cyc, ld_t, rd_t, st_t, send_t;
    bit ok, stable;
    int t_load, t_end;
  } frame_t;

  frame_t frames[$];
  frame_t cur;
  bit     active = 0;
  int     phase = 0, strobe_cyc = 0;
  logic   p_ld = 0, p_rd = 0, p_st = 0, p_busy = 0, p_tick = 0;
  int     irq_pulses = 0, irq_bad = 0, irq_cyc = -1;
  logic   p_irq = 0;

  always @(negedge clk) begin
    if (!rst) active = 0;
    else begin
      if (load_data_reg || byte_ready || transfer_byte) strobe_cyc++;
      if (load_data_reg && !p_ld) begin
        cur = '{default: 0};
        cur.data = tx_data; cur.s2 = stop_2_q; cur.ok = 1; cur.stable = 1; cur.t_load = cyc;
        active = 1; phase = 1;
      end
      if (active) begin
        if (tx_data !== cur.data || stop_2_q !== cur.s2) cur.stable = 0;
        if (int'(load_data_reg) + int'(byte_ready) + int'(transfer_byte) > 1) cur.ok = 0;
        if (byte_ready && !p_rd) begin if (phase != 1) cur.ok = 0; phase = 2; end
        if (transfer_byte && !p_st) begin if (phase != 2) cur.ok = 0; phase = 3; end
        // a strobe may only drop right after the cycle that carried a tick
        if (((p_ld && !load_data_reg) || (p_rd && !byte_ready) || (p_st && !transfer_byte)) && !p_tick)
          cur.ok = 0;
        if (load_data_reg) begin cur.ld_cyc++; if (tick) cur.ld_t++; end
        if (byte_ready)    begin cur.rd_cyc++; if (tick) cur.rd_t++; end
        if (transfer_byte) begin cur.st_cyc++; if (tick) cur.st_t++; end
        if (busy && phase == 3 && !transfer_byte && tick) cur.send_t++;
        if (p_busy && !busy) begin
          cur.t_end = cyc; frames.push_back(cur); active = 0;
        end
      end
    end
`ifdef UART_TX_IRQ_EN
    if (tx_irq) begin
      if (!p_irq) begin irq_pulses++; irq_cyc = cyc; end
      else irq_bad++;
    end
    p_irq = tx_irq;
`endif
    p_ld = load_data_reg; p_rd = byte_ready; p_st = transfer_byte;
    p_busy = busy; p_tick = tick;
  end

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [7:0] b);
    step; wr_en = 1; wr_data = b;
    step; wr_en = 0;
  endtask

  task automatic wait_frames(input int n, input int budget, output bit ok);
    for (int i = 0; i < budget && frames.size() < n; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    ok = (frames.size() >= n);
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_frames: got %0d frames, need %0d", frames.size(), n);
    end
  endtask

  task automatic test_reset;
    #2 rst = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({tx_data, load_data_reg, byte_ready, transfer_byte, stop_2_q, fifo_full, fifo_empty, busy, ovf}
        !== {8'h00, 8'b0000_0100}) begin
      errors++;
      $display("FAIL reset_state: got %h/%b%b%b%b%b%b%b%b want 00/00000100", tx_data, load_data_reg,
               byte_ready, transfer_byte, stop_2_q, fifo_full, fifo_empty, busy, ovf);
    end
    step; rst = 1;
  endtask

  task automatic test_single;
    bit ok;
    tick_div = 4; stop_2 = 0; frames.delete();
    push(8'hA5);
    @(negedge clk);
    checks++;
    if (fifo_empty !== 1'b0 || load_data_reg !== 1'b0) begin
      errors++; $display("FAIL single_flag_lat: empty=%b load=%b want 0/0", fifo_empty, load_data_reg);
    end
    @(negedge clk);
    checks++;
    if (load_data_reg !== 1'b1) begin
      errors++; $display("FAIL single_load_lat: load=%b want 1", load_data_reg);
    end
    wait_frames(1, 400, ok);
    if (ok) begin
      checks++;
      if (frames[0].data !== 8'hA5 || !frames[0].stable) begin
        errors++; $display("FAIL single_data: got %h stable=%0d want a5/1", frames[0].data, frames[0].stable);
      end
      checks++;
      if (!frames[0].ok || frames[0].ld_t != 1 || frames[0].rd_t != 1 || frames[0].st_t != 1) begin
        errors++; $display("FAIL single_strobes: ok=%0d ticks=%0d/%0d/%0d want 1/1/1/1", frames[0].ok,
                           frames[0].ld_t, frames[0].rd_t, frames[0].st_t);
      end
      checks++;
      if (frames[0].send_t != 10) begin
        errors++; $display("FAIL single_send_ticks: got %0d want 10", frames[0].send_t);
      end
    end
    checks++;
    if (fifo_empty !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL single_end: empty=%b busy=%b want 1/0", fifo_empty, busy);
    end
  endtask

  task automatic test_random;
    bit ok;
    logic [7:0] exp_q[$];
    for (int r = 0; r < 4; r++) begin
      int n;
      tick_div = $urandom_range(1, 6);
      stop_2 = $urandom_range(0, 1);
      n = $urandom_range(1, DEPTH);
      frames.delete(); exp_q.delete();
      for (int i = 0; i < n; i++) begin
        logic [7:0] b;
        b = 8'($urandom);
        exp_q.push_back(b);
        repeat ($urandom_range(0, 3)) step;
        push(b);
      end
      wait_frames(n, 3000, ok);
      if (ok) begin
        checks++;
        if (frames.size() != n) begin
          errors++; $display("FAIL rand_count run%0d: got %0d want %0d", r, frames.size(), n);
        end
        for (int i = 0; i < n; i++) begin
          checks++;
          if (frames[i].data !== exp_q[i] || frames[i].s2 !== stop_2 || !frames[i].stable) begin
            errors++; $display("FAIL rand_data run%0d.%0d: got %h s2=%b want %h s2=%b", r, i,
                               frames[i].data, frames[i].s2, exp_q[i], stop_2);
          end
          checks++;
          if (!frames[i].ok || frames[i].send_t != (stop_2 ? 11 : 10)) begin
            errors++; $display("FAIL rand_frame run%0d.%0d: ok=%0d send=%0d want 1/%0d", r, i,
                               frames[i].ok, frames[i].send_t, stop_2 ? 11 : 10);
          end
        end
      end
    end
  endtask

  task automatic test_burst;
    bit ok;
    logic [7:0] exp_q[$];
    tick_div = 4; stop_2 = 0; frames.delete();
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    step;
    foreach (exp_q[i]) begin wr_en = 1; wr_data = exp_q[i]; step; end
    wr_en = 0;
    @(negedge clk);
    checks++;
    if (ovf !== 1'b0 || fifo_full !== 1'b1) begin
      errors++; $display("FAIL burst_full: ovf=%b full=%b want 0/1", ovf, fifo_full);
    end
    push(8'h66);
    @(negedge clk);
    checks++;
    if (ovf !== 1'b1) begin
      errors++; $display("FAIL burst_ovf: got %b want 1", ovf);
    end
    wait_frames(5, 2000, ok);
    repeat (100) @(negedge clk);
    checks++;
    if (frames.size() != 5) begin
      errors++; $display("FAIL burst_count: got %0d want 5", frames.size());
    end
    if (ok) foreach (exp_q[i]) begin
      checks++;
      if (frames[i].data !== exp_q[i] || !frames[i].ok) begin
        errors++; $display("FAIL burst_order %0d: got %h ok=%0d want %h", i, frames[i].data, frames[i].ok, exp_q[i]);
      end
    end
  endtask

  task automatic test_stop2_toggle;
    bit ok;
    tick_div = 3; stop_2 = 1; frames.delete();
    push(8'h3C);
    for (int i = 0; i < 200 && !transfer_byte; i++) @(negedge clk);
    step; stop_2 = 0;
    wait_frames(1, 400, ok);
    if (ok) begin
      checks++;
      if (frames[0].s2 !== 1'b1 || !frames[0].stable || frames[0].send_t != 11) begin
        errors++; $display("FAIL stop2_frame: s2=%b stable=%0d send=%0d want 1/1/11", frames[0].s2,
                           frames[0].stable, frames[0].send_t);
      end
    end
  endtask

  task automatic test_dvsr0;
    bit ok;
    logic [7:0] b;
    b = 8'($urandom);
    tick_div = 1; stop_2 = 0; frames.delete();
    push(b);
    wait_frames(1, 200, ok);
    if (ok) begin
      checks++;
      if (frames[0].ld_cyc != 1 || frames[0].rd_cyc != 1 || frames[0].st_cyc != 1 || frames[0].data !== b) begin
        errors++; $display("FAIL dvsr0_strobes: cyc=%0d/%0d/%0d data=%h want 1/1/1 %h", frames[0].ld_cyc,
                           frames[0].rd_cyc, frames[0].st_cyc, frames[0].data, b);
      end
      checks++;
      if (frames[0].t_end - frames[0].t_load != 13) begin
        errors++; $display("FAIL dvsr0_len: got %0d clk want 13", frames[0].t_end - frames[0].t_load);
      end
    end
  endtask

  task automatic test_reset_mid_send;
    int snap;
    tick_div = 4; stop_2 = 1; frames.delete();
    step;
    for (int i = 0; i < 3; i++) begin wr_en = 1; wr_data = 8'(8'hC0 + i); step; end
    wr_en = 0;
    for (int i = 0; i < 300 && !transfer_byte; i++) @(negedge clk);
    for (int i = 0; i < 300 && transfer_byte; i++) @(negedge clk);
    repeat (6) @(negedge clk);
    #2 rst = 0;
    #1;
    checks++;
    if ({tx_data, load_data_reg, byte_ready, transfer_byte, stop_2_q, fifo_full, fifo_empty, busy, ovf}
        !== {8'h00, 8'b0000_0100}) begin
      errors++;
      $display("FAIL rst_mid_send: got %h/%b%b%b%b%b%b%b%b want 00/00000100", tx_data, load_data_reg,
               byte_ready, transfer_byte, stop_2_q, fifo_full, fifo_empty, busy, ovf);
    end
    step; step; rst = 1;
    snap = strobe_cyc;
    repeat (200) @(negedge clk);
    checks++;
    if (strobe_cyc != snap || fifo_empty !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_after: strobes=%0d empty=%b busy=%b want 0/1/0", strobe_cyc - snap,
                         fifo_empty, busy);
    end
    stop_2 = 0;
  endtask

`ifdef UART_TX_IRQ_EN
  task automatic test_irq;
    bit ok;
    for (int m = 0; m < 2; m++) begin
      tick_div = 2; irq_mask = m[0]; frames.delete();
      irq_pulses = 0; irq_bad = 0; irq_cyc = -1;
      step;
      wr_en = 1; wr_data = 8'h5A; step;
      wr_data = 8'hA5; step;
      wr_en = 0;
      wait_frames(2, 800, ok);
      repeat (10) @(negedge clk);
      checks++;
      if (irq_pulses != (m == 0 ? 1 : 0) || irq_bad != 0) begin
        errors++; $display("FAIL irq_count mask=%0d: pulses=%0d long=%0d want %0d/0", m, irq_pulses,
                           irq_bad, m == 0 ? 1 : 0);
      end
      if (ok && m == 0) begin
        checks++;
        if (irq_cyc != frames[1].t_end) begin
          errors++; $display("FAIL irq_time: got cyc %0d want %0d", irq_cyc, frames[1].t_end);
        end
      end
    end
    irq_mask = 0;
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_random;
    test_stop2_toggle;
    test_dvsr0;
    test_burst;
    test_reset_mid_send;
`ifdef UART_TX_IRQ_EN
    test_irq;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
